// File: rtl/reg_bulk_xfer.sv
// Sequencer for the CHIP-8 FX55/FX65 bulk store/load of V0..Vx at [I], one byte access
// per register over a req/ack memory port, with optional COSMAC-style I advance.
module reg_bulk_xfer #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned I_INCREMENT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dir,
    input  logic [3:0]        x,
    input  logic [15:0]       i_rd,
    output logic              busy,
    output logic              done,
    output logic [3:0]        reg_sel,
    input  logic [7:0]        vx_rd,
    output logic              wx,
    output logic [7:0]        nx,
    output logic              i_en,
    output logic [15:0]       i_wr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {StIdle, StAccess, StUpdateI, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  x_q, x_d;
    logic        dir_q, dir_d;
    logic [15:0] base_q, base_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            k_q     <= 4'd0;
            x_q     <= 4'd0;
            dir_q   <= 1'b0;
            base_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            dir_q   <= dir_d;
            base_q  <= base_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        x_d       = x_q;
        dir_d     = dir_q;
        base_d    = base_q;
        busy      = 1'b0;
        done      = 1'b0;
        reg_sel   = 4'd0;
        wx        = 1'b0;
        nx        = 8'd0;
        i_en      = 1'b0;
        i_wr      = 16'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'd0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dir_d   = dir;
                    x_d     = x;
                    base_d  = i_rd;
                    k_d     = 4'd0;
                    state_d = StAccess;
                end
            end
            StAccess: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = ~dir_q;
                reg_sel   = k_q;
                mem_addr  = base_q[ADDR_W-1:0] + ADDR_W'(k_q);
                mem_wdata = vx_rd;
                if (mem_ack) begin
                    // Load data lands in the register file on the same edge as the ack.
                    if (dir_q) begin
                        wx = 1'b1;
                        nx = mem_rdata;
                    end
                    if (k_q == x_q) begin
                        state_d = (I_INCREMENT != 0) ? StUpdateI : StDone;
                    end else begin
                        k_d = k_q + 4'd1;
                    end
                end
            end
            StUpdateI: begin
                busy    = 1'b1;
                i_en    = 1'b1;
                i_wr    = base_q + 16'(x_q) + 16'd1;
                state_d = StDone;
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule
